// File: rtl/cache_bus_pkg.sv
// cache_bus_pkg: bus tags, line geometry and fill-engine states shared by the cache,
// the line-fill engine and the write-back engine.
package cache_bus_pkg;
    localparam int DATA_W = 64;
    localparam int TAG_W = 13;
    localparam int LINE_B = 64;
    localparam int LINE_W = LINE_B * 8;
    localparam int BEATS = LINE_W / DATA_W;
    // bit 12 marks a read, [11:8] select the memory target
    localparam logic [12:0] READ_TAG = 13'b1_0001_0000_0000;
    typedef enum logic [2:0] {IDLE, ARB, REQ, RESP, DONE} fill_state_t;
endpackage

// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: arbiter handshake plus main-bus request/response channels.
interface cache_line_fill_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH = 13
);
    logic abtr_reqcyc;
    logic abtr_grant;
    logic [BUS_DATA_WIDTH-1:0] main_bus_req;
    logic [BUS_TAG_WIDTH-1:0] main_bus_reqtag;
    logic main_bus_reqcyc;
    logic main_bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] main_bus_resp;
    logic [BUS_TAG_WIDTH-1:0] main_bus_resptag;
    logic main_bus_respcyc;
    logic main_bus_respack;
    modport master (
        output abtr_reqcyc, main_bus_req, main_bus_reqtag, main_bus_reqcyc, main_bus_respack,
        input abtr_grant, main_bus_reqack, main_bus_resp, main_bus_resptag, main_bus_respcyc
    );
    modport slave (
        input abtr_reqcyc, main_bus_req, main_bus_reqtag, main_bus_reqcyc, main_bus_respack,
        output abtr_grant, main_bus_reqack, main_bus_resp, main_bus_resptag, main_bus_respcyc
    );
endinterface

// File: rtl/cache_line_fill.sv
// cache_line_fill: arbitrates for the main bus, issues one line read and assembles
// the returned beats into a full cache line.
module cache_line_fill
    import cache_bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = DATA_W,
    parameter int BUS_TAG_WIDTH = TAG_W,
    parameter int LINE_BYTES = LINE_B
) (
    input logic clk,
    input logic reset,
    input logic enable,
    input logic [63:0] addr,
    output logic [LINE_BYTES*8-1:0] data,
    output logic ready,
    output logic bus_busy,
    cache_line_fill_if.master bus
);
    localparam int NB = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [BUS_TAG_WIDTH-1:0] TAG = BUS_TAG_WIDTH'(READ_TAG);
    fill_state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [63:0] addr_q;
    logic start, take, last;
    always_comb begin
        start = enable && (state == IDLE || state == DONE);
        take = state == RESP && bus.main_bus_respcyc && bus.main_bus_resptag == TAG;
        last = take && cnt == CW'(NB - 1);
        state_nx = start ? ARB :
                   state == ARB ? (bus.abtr_grant ? REQ : ARB) :
                   state == REQ ? (bus.main_bus_reqack ? RESP : REQ) :
                   state == RESP ? (last ? DONE : RESP) : IDLE;
    end
    // request lines are shared with the write-back engine, so they are zero outside REQ
    assign bus.abtr_reqcyc = state == ARB || state == REQ || state == RESP;
    assign bus.main_bus_reqcyc = state == REQ;
    assign bus.main_bus_req = state == REQ ? BUS_DATA_WIDTH'(addr_q) : '0;
    assign bus.main_bus_reqtag = state == REQ ? TAG : '0;
    assign bus.main_bus_respack = take;
    assign bus_busy = state == REQ || state == RESP;
    assign ready = state == DONE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            data <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q <= addr & {{58{1'b1}}, 6'b0};
                cnt <= '0;
            end
            if (take) begin
                data[cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus.main_bus_resp;
                if (!last) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: directed and randomized line fills checked every cycle against
// a transaction-level model of the fill engine.
module tb_cache_line_fill;
    import cache_bus_pkg::*;
    localparam logic [12:0] TAG = READ_TAG;
    logic clk = 0, reset = 0, enable = 0;
    logic [63:0] addr = '0;
    logic [511:0] data;
    logic ready, bus_busy;
    cache_line_fill_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus();
    cache_line_fill dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr),
        .data(data), .ready(ready), .bus_busy(bus_busy), .bus(bus)
    );
    always #5 clk = ~clk;
    int cyc = 0, errors = 0, checks = 0, mode = 0, t0 = 0, n_ack = 0, rel = 0;
    int q_ready[$];
    logic [63:0] q_req[$];
    bit prev_reqcyc = 0, req_v = 0, ack_v = 0;
    // model: an outstanding fill, whether grant and reqack were seen, and the line so far
    bit active = 0, granted = 0, acked = 0, done_p = 0;
    int nbeats = 0;
    logic [63:0] m_addr = '0;
    logic [511:0] m_data = '0;
    task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    always @(posedge clk) cyc++;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            active = 0; granted = 0; acked = 0; done_p = 0; nbeats = 0;
            m_addr = '0; m_data = '0;
        end else begin
            done_p = 0;
            if (active) begin
                if (!granted) granted = bus.abtr_grant;
                else if (!acked) acked = bus.main_bus_reqack;
                else if (bus.main_bus_respcyc && bus.main_bus_resptag == TAG) begin
                    m_data[nbeats*64 +: 64] = bus.main_bus_resp;
                    nbeats++;
                    if (nbeats == 8) begin
                        active = 0;
                        done_p = 1;
                    end
                end
            end else if (enable) begin
                active = 1; granted = 0; acked = 0; nbeats = 0;
                m_addr = {addr[63:6], 6'b0};
            end
        end
    end
    always @(negedge clk) begin
        if (cyc > 0) begin
            req_v = active && granted && !acked;
            ack_v = active && granted && acked && bus.main_bus_respcyc && bus.main_bus_resptag == TAG;
            chk("abtr_reqcyc", bus.abtr_reqcyc, active);
            chk("bus_busy", bus_busy, active && granted);
            chk("reqcyc", bus.main_bus_reqcyc, req_v);
            chk("req", bus.main_bus_req, req_v ? m_addr : 64'd0);
            chk("reqtag", bus.main_bus_reqtag, req_v ? TAG : 13'd0);
            chk("respack", bus.main_bus_respack, ack_v);
            chk("ready", ready, done_p);
            chk("data", data, m_data);
            if (ready) q_ready.push_back(cyc);
            if (bus.main_bus_reqcyc && !prev_reqcyc) q_req.push_back(bus.main_bus_req);
            prev_reqcyc = bus.main_bus_reqcyc;
            if (bus.main_bus_respack) n_ack++;
        end
    end
    always begin
        @(posedge clk);
        #1;
        rel = cyc - t0;
        case (mode)
            0: begin
                bus.abtr_grant = 1; bus.main_bus_reqack = 1; bus.main_bus_respcyc = 1;
                bus.main_bus_resptag = TAG; bus.main_bus_resp = 64'hA0 + 64'(nbeats);
            end
            1: begin
                bus.abtr_grant = rel == 6; bus.main_bus_reqack = rel == 10; bus.main_bus_respcyc = 1;
                bus.main_bus_resptag = TAG; bus.main_bus_resp = 64'hA0 + 64'(nbeats);
            end
            2: begin
                bus.abtr_grant = 1; bus.main_bus_reqack = 1; bus.main_bus_respcyc = rel[0];
                bus.main_bus_resptag = rel == 5 ? 13'd0 : TAG; bus.main_bus_resp = {$urandom, $urandom};
            end
            default: begin
                bus.abtr_grant = $urandom_range(0, 99) < 50;
                bus.main_bus_reqack = $urandom_range(0, 99) < 50;
                bus.main_bus_respcyc = $urandom_range(0, 99) < 60;
                bus.main_bus_resptag = $urandom_range(0, 9) == 0 ? 13'($urandom) : TAG;
                bus.main_bus_resp = {$urandom, $urandom};
            end
        endcase
    end
    task automatic pulse(input logic [63:0] a, output int t);
        @(posedge clk);
        #1;
        enable = 1; addr = a; t = cyc; t0 = cyc;
        @(posedge clk);
        #1;
        enable = 0; addr = {$urandom, $urandom};
    endtask
    task automatic clear_obs();
        q_ready.delete();
        q_req.delete();
        n_ack = 0;
    endtask
    initial begin
        int t, t1, t2;
        bus.abtr_grant = 0; bus.main_bus_reqack = 0; bus.main_bus_respcyc = 0;
        bus.main_bus_resptag = '0; bus.main_bus_resp = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        chk("reset_data", data, 0);
        chk("reset_ready", ready, 0);
        mode = 0; clear_obs();
        pulse(64'h1047, t);
        repeat (14) @(posedge clk);
        #1;
        chk("basic_nready", q_ready.size(), 1);
        chk("basic_lat", q_ready.size() > 0 ? q_ready[0] - t : -1, 11);
        chk("basic_req", q_req.size() > 0 ? q_req[0] : '1, 64'h1040);
        chk("basic_lo", data[63:0], 64'hA0);
        chk("basic_hi", data[511:448], 64'hA7);
        chk("basic_acks", n_ack, 8);
        mode = 1; clear_obs();
        pulse(64'hDEAD_BEEF_0000_0FFF, t);
        repeat (22) @(posedge clk);
        #1;
        chk("stall_lat", q_ready.size() > 0 ? q_ready[0] - t : -1, 19);
        chk("stall_nreq", q_req.size(), 1);
        chk("stall_req", q_req.size() > 0 ? q_req[0] : '1, 64'hDEAD_BEEF_0000_0FC0);
        mode = 2; clear_obs();
        pulse(64'h40, t);
        repeat (24) @(posedge clk);
        #1;
        chk("gap_lat", q_ready.size() > 0 ? q_ready[0] - t : -1, 20);
        chk("gap_acks", n_ack, 8);
        mode = 0; clear_obs();
        pulse(64'h3000, t);
        for (int i = 0; i < 30 && nbeats != 3; i++) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("rst_busy", bus_busy, 0);
        chk("rst_abtr", bus.abtr_reqcyc, 0);
        chk("rst_data", data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        chk("rst_noready", q_ready.size(), 0);
        clear_obs();
        pulse(64'h5555_0000_0000_0080, t);
        repeat (14) @(posedge clk);
        #1;
        chk("refill_lat", q_ready.size() > 0 ? q_ready[0] - t : -1, 11);
        chk("refill_hi", data[511:448], 64'hA7);
        clear_obs();
        pulse(64'h2000_0000_0000_1234, t);
        repeat (3) @(posedge clk);
        pulse(64'h9999_0000_0000_0000, t1);
        repeat (4) @(posedge clk);
        pulse(64'h0000_7777_0000_00FF, t2);
        repeat (14) @(posedge clk);
        #1;
        chk("busy_nready", q_ready.size(), 2);
        chk("busy_lat0", q_ready.size() > 0 ? q_ready[0] - t : -1, 11);
        chk("busy_lat1", q_ready.size() > 1 ? q_ready[1] - t : -1, 22);
        chk("busy_req0", q_req.size() > 0 ? q_req[0] : '1, 64'h2000_0000_0000_1200);
        chk("busy_req1", q_req.size() > 1 ? q_req[1] : '1, 64'h0000_7777_0000_00C0);
        mode = 3;
        for (int i = 0; i < 40; i++) begin
            pulse({$urandom, $urandom}, t);
            repeat ($urandom_range(0, 60)) @(posedge clk);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
                reset = 0;
                @(posedge clk);
                #1;
                reset = 1;
            end
        end
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Line-fill engine between the set-associative cache and the shared main bus.
- On an enable pulse it requests bus ownership from the arbiter and issues one read for a 64-byte aligned block.
- It collects the response beats into one 512-bit line and pulses ready to the cache's miss handler.
- It is the fill path the cache uses for FLUSHING_NOT_NEEDED misses and after a write-back completes.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req/bus_resp.
- BUS_TAG_WIDTH, 13, width of bus_reqtag/bus_resptag.
- LINE_BYTES, 64, cache block size in bytes. BEATS = LINE_BYTES*8/BUS_DATA_WIDTH (8 at defaults).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  one-cycle fill request from the cache.
- addr  in  64  physical address; bits [5:0] are ignored.
- data  out  LINE_BYTES*8  assembled line; beat i occupies [64i+63:64i].
- ready  out  1  one-cycle pulse when data is valid.
- bus_busy  out  1  high while this block owns the bus.
- abtr_reqcyc  out  1  bus-ownership request to the arbiter.
- abtr_grant  in  1  arbiter grant.
- main_bus_req  out  BUS_DATA_WIDTH  request address.
- main_bus_reqtag  out  BUS_TAG_WIDTH  request tag.
- main_bus_reqcyc  out  1  request valid.
- main_bus_reqack  in  1  request accepted.
- main_bus_resp  in  BUS_DATA_WIDTH  response beat.
- main_bus_resptag  in  BUS_TAG_WIDTH  response tag.
- main_bus_respcyc  in  1  response beat valid.
- main_bus_respack  out  1  beat accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, beat counter=0, latched address=0, data=0.
  - ready, bus_busy, abtr_reqcyc, main_bus_reqcyc and main_bus_respack are 0.
  - main_bus_req and main_bus_reqtag are 0.
- States: IDLE, ARB, REQ, RESP, DONE.
- IDLE or DONE with enable=1:
  - Latch {addr[63:6],6'b0}, clear the beat counter, go to ARB.
  - data keeps its previous value until overwritten beat by beat.
- Enable while in ARB, REQ or RESP is ignored; there is no queueing.
- ARB: abtr_reqcyc=1 (registered). Stay until abtr_grant=1, then go to REQ.
- REQ:
  - bus_busy=1, main_bus_reqcyc=1, main_bus_req=latched address, main_bus_reqtag=READ_TAG.
  - Hold all of these stable until main_bus_reqack=1, then go to RESP.
  - abtr_reqcyc stays 1 from ARB until RESP exits.
- RESP:
  - bus_busy=1.
  - A beat is accepted in a cycle where main_bus_respcyc=1 and main_bus_resptag==READ_TAG.
  - main_bus_respack=1 combinationally in that same cycle.
  - The beat is written to slot[counter] and the counter increments.
  - A beat with a mismatched tag is not acked and not counted.
  - Gaps (respcyc=0) are allowed, with no timeout.
  - After beat BEATS-1 is accepted, go to DONE. The counter does not wrap within a line.
- DONE:
  - ready=1 for exactly one cycle.
  - bus_busy, abtr_reqcyc and main_bus_respack drop to 0.
  - data stays stable until the next accepted enable.
  - Without enable, go to IDLE next cycle.
- Outside REQ, main_bus_req/reqtag/reqcyc are driven 0. This is required because the outputs are shared with the write-back engine.
- Minimum latency with grant, reqack and beats all immediate:
  - enable at T; abtr_reqcyc at T+1; reqcyc at T+2.
  - Beats at T+3..T+10; ready at T+11.
- Reset mid-operation: return to IDLE immediately with all outputs at their reset values. The partial line is discarded and no ready is produced.
- enable and reset asserted together: reset wins.

Decomposition:
- Package cache_bus_pkg:
  - fill_state_t enum (IDLE, ARB, REQ, RESP, DONE).
  - READ_TAG constant: 13'b1_0001_0000_0000 (bit 12 = read, [11:8] = memory target).
  - BEATS and line-width localparams shared with the cache and the write-back engine.
- No sub-module. Beat steering is an indexed write into the data register within this block.

Test Plan:
- Basic fill: enable with addr=0x1047; grant, reqack and 8 beats (value i+0xA0) immediate → main_bus_req=0x1040, reqtag=READ_TAG; ready at T+11; data[63:0]=0xA0 and data[511:448]=0xA7; eight respack pulses.
- Arbiter stall: grant delayed 5 cycles, then reqack delayed 3 cycles → abtr_reqcyc held; reqcyc and req stable throughout; ready at T+19.
- Beat gaps and foreign tag: respcyc idle on alternating cycles, plus one beat with resptag=0 → that beat gets no respack and is not stored; line completes after 8 matching beats.
- Reset mid-RESP: reset=0 after beat 3 → all outputs 0 the same cycle, no ready; a fresh enable afterwards completes normally.
- Busy enable: second enable during RESP with another address → ignored; the first line returns; a second enable in the DONE cycle starts a new fill with no idle cycle.
